// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with glitch filter, frame checks, RX FIFO and 32-bit regs.
// Define PS2_RX_TIMEOUT_EN to build the stalled-frame timeout abort.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Ps2Clk,
  input  logic        i_Ps2Sda,
  input  logic        i_WEnable,
  input  logic [31:0] i_WAddr,
  input  logic [31:0] i_WData,
  input  logic        i_REnable,
  input  logic [31:0] i_RAddr,
  output logic [31:0] o_RData,
  output logic        o_Err,
  output logic        o_Irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PAR, S_STOP
  } state_t;

  logic [1:0]    r_clk_sync, r_sda_sync;
  logic [FW-1:0] r_clk_cnt, r_sda_cnt;
  logic          r_clk_f, r_sda_f, r_clk_d;
  logic          w_fall;

  state_t        r_state;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_push, r_perr_set, r_ferr_set;
  logic          w_tout;

  logic          r_en, r_irq_en;
  logic          r_ovf, r_perr, r_ferr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic          w_wr_ctrl, w_wr_stat, w_rd_data;
  logic          w_empty, w_full, w_pop, w_flush;
  logic          w_push_ok, w_ovf_set;
  logic [2:0]    w_w1c;
  logic          w_unused;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_clk_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_Ps2Clk};
      r_sda_sync <= {r_sda_sync[0], i_Ps2Sda};
    end
  end

  // A new level is taken only after FILTER_LEN consecutive samples of it
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_clk_cnt <= '0;
      r_clk_f   <= 1'b1;
      r_clk_d   <= 1'b1;
    end else begin
      r_clk_d <= r_clk_f;
      if (r_clk_sync[1] == r_clk_f) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_f   <= r_clk_sync[1];
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_sda_cnt <= '0;
      r_sda_f   <= 1'b1;
    end else if (r_sda_sync[1] == r_sda_f) begin
      r_sda_cnt <= '0;
    end else if (r_sda_cnt == FW'(FILTER_LEN - 1)) begin
      r_sda_f   <= r_sda_sync[1];
      r_sda_cnt <= '0;
    end else begin
      r_sda_cnt <= r_sda_cnt + 1'b1;
    end
  end

  assign w_fall = r_clk_d & ~r_clk_f;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_tcnt <= '0;
    end else if (r_state == S_IDLE || w_fall || !r_en) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_tout = (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) &&
                  (r_state != S_IDLE) && !w_fall;
`else
  assign w_tout = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state    <= S_IDLE;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_push     <= 1'b0;
      r_perr_set <= 1'b0;
      r_ferr_set <= 1'b0;
    end else begin
      r_push     <= 1'b0;
      r_perr_set <= 1'b0;
      r_ferr_set <= 1'b0;
      if (!r_en) begin
        r_state <= S_IDLE;
      end else if (w_tout) begin
        r_state    <= S_IDLE;
        r_ferr_set <= 1'b1;
      end else if (w_fall) begin
        unique case (r_state)
          S_IDLE: begin
            if (!r_sda_f) begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {r_sda_f, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= S_PAR;
          end
          S_PAR: begin
            r_par   <= ^{r_shift, r_sda_f};
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (r_sda_f && r_par) begin
              r_push <= 1'b1;
            end else begin
              r_perr_set <= ~r_par;
              r_ferr_set <= ~r_sda_f;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_wr_ctrl = i_WEnable & (i_WAddr[3:2] == 2'd0);
  assign w_wr_stat = i_WEnable & (i_WAddr[3:2] == 2'd1);
  assign w_rd_data = i_REnable & (i_RAddr[3:2] == 2'd2);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = w_rd_data & ~w_empty;
  assign w_flush   = w_wr_ctrl & i_WData[2];
  // A pop in the same cycle frees the slot for a push into a full FIFO
  assign w_push_ok = r_push & (~w_full | w_pop);
  assign w_ovf_set = r_push & w_full & ~w_pop & ~w_flush;
  assign w_w1c     = w_wr_stat ? i_WData[4:2] : 3'b000;

  always_ff @(posedge i_Clk) begin
    if (w_push_ok && !w_flush) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= i_WData[0];
        r_irq_en <= i_WData[1];
      end
      r_ovf  <= (r_ovf & ~w_w1c[0]) | w_ovf_set;
      r_perr <= (r_perr & ~w_w1c[1]) | r_perr_set;
      r_ferr <= (r_ferr & ~w_w1c[2]) | r_ferr_set;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_RData <= '0;
    end else if (i_REnable) begin
      unique case (i_RAddr[3:2])
        2'd0: o_RData <= {30'b0, r_irq_en, r_en};
        2'd1: o_RData <= {17'b0, 7'(r_count), 3'b0,
                          r_ferr, r_perr, r_ovf, w_full, w_empty};
        2'd2: o_RData <= w_empty ? 32'b0 :
                         {23'b0, 1'b1, r_mem[r_rptr]};
        default: o_RData <= '0;
      endcase
    end
  end

  assign o_Irq = r_irq_en & ~w_empty;
  assign o_Err = r_ovf | r_perr | r_ferr;

  assign w_unused = ^{i_WAddr[31:4], i_WAddr[1:0], i_RAddr[31:4],
                      i_RAddr[1:0], i_WData[31:5], 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomized bench for ps2_rx_fifo against a queue-based reference model.
// Timeout scenario runs only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int FL    = 8;
  localparam int TO    = 50;
  localparam int H     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2c, ps2d;
  logic        we, re;
  logic [31:0] waddr, wdata, raddr;
  logic [31:0] rdata;
  logic        err, irq;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clk(clk), .i_Rst(rst_n),
    .i_Ps2Clk(ps2c), .i_Ps2Sda(ps2d),
    .i_WEnable(we), .i_WAddr(waddr), .i_WData(wdata),
    .i_REnable(re), .i_RAddr(raddr),
    .o_RData(rdata), .o_Err(err), .o_Irq(irq)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];
  bit m_en, m_irqen, m_ovf, m_perr, m_ferr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    waddr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] r);
    raddr = a; re = 1'b1;
    tick();
    re = 1'b0;
    r = rdata;
  endtask

  function automatic logic [31:0] m_status();
    int n;
    n = q.size();
    return (n << 8) + (int'(m_ferr) << 4) + (int'(m_perr) << 3) +
           (int'(m_ovf) << 2) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0);
  endfunction

  function automatic logic [31:0] m_pop();
    logic [7:0] b;
    if (q.size() == 0) return 32'h0;
    b = q.pop_front();
    return 32'h100 + b;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (q.size() == DEPTH) m_ovf = 1'b1;
    else q.push_back(b);
  endfunction

  task automatic ctrl_wr(input logic [31:0] d);
    reg_wr(32'h0, d);
    m_en = d[0];
    m_irqen = d[1];
    if (d[2]) q.delete();
  endtask

  task automatic w1c(input logic [31:0] d);
    reg_wr(32'h4, d);
    if (d[2]) m_ovf = 1'b0;
    if (d[3]) m_perr = 1'b0;
    if (d[4]) m_ferr = 1'b0;
  endtask

  task automatic ck_status(input string tag);
    logic [31:0] r;
    reg_rd(32'h4, r);
    chk(tag, r, m_status());
    chk({tag, "_err"}, err, m_ovf | m_perr | m_ferr);
    chk({tag, "_irq"}, irq, m_irqen && q.size() != 0);
  endtask

  task automatic ck_data(input string tag);
    logic [31:0] r;
    reg_rd(32'h8, r);
    chk(tag, r, m_pop());
  endtask

  task automatic ps2_bit(input logic b);
    ps2d = b;
    repeat (H) tick();
    ps2c = 1'b0;
    repeat (H) tick();
    ps2c = 1'b1;
  endtask

  // kind: 0 good, 1 parity error, 2 stop error; rd_d >= 0 reads DATA
  // rd_d cycles after the stop-bit clock falls
  task automatic send_frame(input logic [7:0] b, input int kind,
                            input int rd_d);
    logic        par;
    logic [31:0] rv, ex;
    par = ~^b;
    if (kind == 1) par = ~par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2d = (kind != 2);
    repeat (H) tick();
    ps2c = 1'b0;
    ex = 32'h0;
    if (rd_d >= 0) begin
      repeat (rd_d) tick();
      raddr = 32'h8; re = 1'b1;
      tick();
      re = 1'b0;
      rv = rdata;
      ex = m_pop();
      chk("simul_rd", rv, ex);
      repeat (H - rd_d - 1) tick();
    end else begin
      repeat (H) tick();
    end
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (20) tick();
    if (m_en) begin
      if (kind == 0) m_push(b);
      else if (kind == 1) m_perr = 1'b1;
      else m_ferr = 1'b1;
    end
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int op, kind;
    rst_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1;
    we = 1'b0; re = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    m_en = 0; m_irqen = 0; m_ovf = 0; m_perr = 0; m_ferr = 0;
    repeat (3) tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_irq", irq, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();
    reg_rd(32'h0, r);
    chk("rst_ctrl", r, 32'h0);
    ck_status("rst_status");

    send_frame(8'h11, 0, -1);
    ck_status("en0_status");
    ctrl_wr(32'h7);
    reg_rd(32'h0, r);
    chk("ctrl_rd", r, 32'h3);
    reg_rd(32'hC, r);
    chk("reg_c", r, 32'h0);

    send_frame(8'h1C, 0, -1);
    ck_status("single_status");
    ck_data("single_data");
    ck_status("single_empty");
    ck_data("empty_data");

    send_frame(8'h1C, 1, -1);
    ck_status("perr_status");
    w1c(32'h8);
    ck_status("perr_clear");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, -1);
    ck_status("ovf_status");
    for (int i = 0; i < 8; i++) ck_data("ovf_data");
    w1c(32'h1C);

    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 0, -1);
    send_frame(8'hA5, 0, FL + 3);
    ck_status("simul_status");
    send_frame(8'h3C, 0, FL);
    ck_status("early_status");
    ctrl_wr(32'h7);
    ck_status("flush_status");

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        kind = 0;
        if ($urandom_range(0, 6) == 0) kind = 1;
        else if ($urandom_range(0, 6) == 0) kind = 2;
        send_frame(8'($urandom), kind, -1);
      end else if (op <= 7) begin
        ck_data("rnd_data");
      end else if (op == 8) begin
        ck_status("rnd_status");
      end else begin
        w1c($urandom & 32'h1C);
        ck_status("rnd_w1c");
      end
    end
    while (q.size() != 0) ck_data("drain_data");
    w1c(32'h1C);
    ck_status("drain_status");

`ifdef PS2_RX_TIMEOUT_EN
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    repeat (80) tick();
    m_ferr = 1'b1;
    ck_status("tout_status");
    w1c(32'h10);
    send_frame(8'h5A, 0, -1);
    ck_data("tout_next");
`endif

    ps2d = 1'b0;
    ps2c = 1'b0;
    tick();
    ps2c = 1'b1;
    repeat (30) tick();
    ps2d = 1'b1;
    repeat (20) tick();
    send_frame(8'h33, 0, -1);
    ck_status("glitch_status");
    ck_data("glitch_data");

    send_frame(8'h44, 1, -1);
    send_frame(8'h55, 0, -1);
    ck_status("pre_rst_status");
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #2;
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_err", err, 1'b0);
    chk("arst_irq", irq, 1'b0);
    q.delete();
    m_en = 0; m_irqen = 0; m_ovf = 0; m_perr = 0; m_ferr = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    ck_status("post_rst_status");
    ctrl_wr(32'h3);
    send_frame(8'h2B, 0, -1);
    ck_status("post_rst_frame");
    ck_data("post_rst_data");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with input filtering, frame and parity checking, a receive FIFO and a 32-bit memory-mapped register interface. It is the next-generation replacement for the single-byte PS2 receiver on the AXI-lite register bridge in the UART/GPIO test project, and sits between the keyboard pins and the CPU register bus. New behaviour: buffering of multiple scan codes, stall timeout, sticky error flags and an interrupt output.

## Interface
- FIFO_DEPTH, 8: receive FIFO entries; power of two, 2..64.
- FILTER_LEN, 8: consecutive equal `i_Clk` samples needed to accept a new `i_Ps2Clk`/`i_Ps2Sda` level; valid range 2..32.
- TIMEOUT_CYCLES, 100000: idle `i_Clk` cycles inside a frame that abort it.

Clock and reset: one clock; reset is asynchronous and active-low.
- i_Clk  in  1  system clock; every register is clocked on its rising edge.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Ps2Clk  in  1  PS/2 clock from the pin, asynchronous.
- i_Ps2Sda  in  1  PS/2 data from the pin, asynchronous.
- i_WEnable  in  1  write strobe, one cycle.
- i_WAddr  in  32  write byte address; bits [3:2] are decoded.
- i_WData  in  32  write data.
- i_REnable  in  1  read strobe, one cycle.
- i_RAddr  in  32  read byte address; bits [3:2] are decoded.
- o_RData  out  32  read data, registered.
- o_Err  out  1  OR of the sticky error flags.
- o_Irq  out  1  level interrupt.

## Operation
- Input path:
  - `i_Ps2Clk` and `i_Ps2Sda` each pass a 2-flop synchroniser, then a FILTER_LEN glitch filter.
  - A falling edge of the filtered PS/2 clock is a sample event.
- Receive FSM states:
  - IDLE:
    - A sample event with data 0 goes to DATA; with data 1 the event is ignored.
  - DATA:
    - Shifts in 8 bits, LSB first.
    - Goes to PARITY after bit 7.
  - PARITY:
    - Samples the parity bit; go to STOP.
    - Odd parity over data+parity is required.
  - STOP:
    - Samples the stop bit; stop=1 is required.
    - On a valid frame with parity OK, the byte is pushed.
    - Otherwise the byte is discarded, PERR or FERR is set, and the FSM returns to IDLE.
- Receiver enable:
  - With CTRL.EN=0 the FSM is held in IDLE.
  - Clearing EN mid-frame aborts the frame silently.
- Registers, decoded from address bits [3:2]:
  - 0x0 CTRL, R/W, reset 0:
    - bit0 EN; bit1 IRQ_EN.
    - bit2 FLUSH: write-only; empties the FIFO in the same cycle; reads as 0.
  - 0x4 STATUS:
    - bit0 EMPTY, bit1 FULL.
    - bit2 OVF, bit3 PERR, bit4 FERR: sticky, write-1-to-clear.
    - bits[14:8] COUNT.
  - 0x8 DATA, RO:
    - Returns {23'b0, VALID, byte}.
    - A read with the FIFO not empty pops one entry.
    - A read with the FIFO empty returns 0 and has no side effects.
  - 0xC reads 0; writes are ignored.
- FIFO:
  - Full with a push pending: the byte is dropped and OVF is set.
  - Push and pop in the same cycle: both take effect and COUNT is unchanged.
  - This holds even when the FIFO is full: the pop frees an entry, so the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- FLUSH and push in the same cycle: flush wins and the FIFO ends empty.
- W1C and a hardware error set in the same cycle: the set wins.
- o_Irq = IRQ_EN & ~EMPTY.
- o_Err = OVF | PERR | FERR.

## Timing
- Reset values:
  - o_RData=0, o_Err=0, o_Irq=0.
  - CTRL=0, FIFO empty, FSM in IDLE, all flags 0.
- Reset is asynchronous and active-low.
  - Asserting i_Rst mid-frame discards the partial byte.
  - After release, the first accepted frame must start with a fresh start bit.
- Input latency: a pin edge reaches the FSM 2 + FILTER_LEN cycles after it occurs.
- Push latency:
  - The byte is pushed on the cycle after the stop-bit sample event.
  - EMPTY falls and o_Irq rises one cycle later.
- Read latency:
  - o_RData is valid 1 cycle after the i_REnable cycle.
  - The pop takes effect on the same edge that registers o_RData.
  - Back-to-back reads are supported.
  - o_RData holds its value when i_REnable=0.
- Writes take effect on the clock edge where i_WEnable=1.
- If read and write strobes hit the same register in the same cycle, the read returns the pre-write value.
- Timeout:
  - A counter of cycles since the last sample event is active outside IDLE.
  - On reaching TIMEOUT_CYCLES it sets FERR and returns the FSM to IDLE.

## Configuration
- PS2_RX_TIMEOUT_EN:
  - Defined: the timeout counter and its abort are built.
  - Undefined:
    - No counter logic is present and a stalled frame waits indefinitely.
    - TIMEOUT_CYCLES is ignored.

## Test plan
- Single frame: EN=1, send 0x1C with correct odd parity (P=0) and stop=1 → DATA reads 0x0000011C, then EMPTY=1 and DATA reads 0.
- Parity error: send 0x1C with P=1 → FIFO stays empty, STATUS.PERR=1, o_Err=1; write STATUS=0x8 → PERR=0, o_Err=0.
- Overflow: FIFO_DEPTH=8, send 9 frames 0x01..0x09 → COUNT=8, FULL=1, OVF=1; reads return 0x101..0x108 in order.
- Simultaneous push and pop on a full FIFO: time a DATA read to the push cycle → COUNT stays 8 and OVF stays 0.
- Timeout (macro defined, TIMEOUT_CYCLES=50): start bit plus 3 data bits, then stall → FERR=1 after 50 idle cycles; the next full frame 0x5A is received correctly.
- Glitch and reset:
  - A 1-cycle low pulse on i_Ps2Clk is ignored.
  - i_Rst=0 mid-frame → all outputs 0; a subsequent frame 0x2B reads back as 0x12B.
